// File: rtl/uart_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_pkg
//   Shared UART definitions: FSM state encoding, baud divisor helper and
//   parity helper. Intended to be reused by the receive side as well.
//   Optional feature macro used by the importers: UART_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_tx_serializer_pkg;

    // Frame phases of the serializer. PARITY is only visited when the
    // parity bit is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per serial bit; integer division truncates.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Parity over a zero-extended data word: even parity when odd == 0,
    // odd parity when odd == 1. Zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_tx_serializer_pkg

// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
//   Handshake bundle between an upstream sender and the UART serializer.
//   Signals:
//     send     1-cycle request strobe (upstream -> serializer)
//     data_in  DATA_BITS word to transmit (upstream -> serializer)
//     tx       serial line, idles high (serializer -> line)
//     busy     frame in progress (serializer -> upstream)
//     done     1-cycle frame-complete pulse (serializer -> upstream)
//   Modports: master = upstream sender, slave = serializer.
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 send;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output send,
        output data_in,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  send,
        input  data_in,
        output tx,
        output busy,
        output done
    );
endinterface : uart_tx_serializer_if

// File: rtl/uart_tx_serializer_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
//   Bit-period timer for the serializer. Counts 0..CLKS_PER_BIT-1 while
//   enabled and flags the last cycle of each bit period.
//   Ports:
//     clk      system clock
//     rst_n    synchronous active-low reset
//     clear    restart the count at 0 (frame acceptance)
//     en       count enable (high while a frame is on the line)
//     bit_end  high during the terminal-count cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic bit_end
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter; held at zero whenever the line is idle so every
    // frame starts with a full-length start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == TERMINAL) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign bit_end = en && (cnt_r == TERMINAL);

endmodule : uart_baud_counter

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit stage: accepts a 1-cycle send strobe with a parallel word
//   and shifts out start(0), data LSB-first, optional parity, stop(1) bits.
//   Ports:
//     clk      system clock, all logic on posedge
//     rst_n    synchronous active-low reset (aborts any frame in flight)
//     bus      uart_tx_serializer_if.slave: send, data_in in; tx, busy, done out
//   Optional feature: define UART_PARITY_EN to insert a parity bit after the
//   data bits (even when PARITY_ODD == 0, odd when PARITY_ODD == 1).
//   tx, busy and done are driven straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_serializer_if.slave   bus
);
    import uart_tx_serializer_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    if (CLKS_PER_BIT < 2) begin : g_bad_divisor
        $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..8");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_sel
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    uart_state_e          state_r;
    logic [DATA_BITS-1:0] data_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 baud_en_s;
    logic                 bit_end_s;
    logic [IDX_W-1:0]     next_idx_s;
    logic [DATA_BITS-1:0] shifted_s;

    // A request only counts while idle; anything during a frame is dropped.
    assign accept_s  = (state_r == ST_IDLE) && bus.send;
    assign baud_en_s = (state_r != ST_IDLE);

    // Next data bit to present: the latched word shifted down by the index.
    assign next_idx_s = bit_idx_r + IDX_W'(1);
    assign shifted_s  = data_r >> next_idx_s;

`ifdef UART_PARITY_EN
    logic parity_s;

    // Parity is taken from the latched word, not from the live input.
    assign parity_s = parity_bit(8'(data_r), (PARITY_ODD != 0));
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_s),
        .en      (baud_en_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            data_r    <= {DATA_BITS{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r      <= 1'b1;
                    done_r    <= 1'b0;
                    bit_idx_r <= {IDX_W{1'b0}};
                    if (bus.send) begin
                        data_r  <= bus.data_in;
                        busy_r  <= 1'b1;
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        tx_r      <= data_r[0];
                        bit_idx_r <= {IDX_W{1'b0}};
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_DATA_IDX) begin
                            bit_idx_r <= {IDX_W{1'b0}};
`ifdef UART_PARITY_EN
                            tx_r      <= parity_s;
                            state_r   <= ST_PARITY;
`else
                            tx_r      <= 1'b1;
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            tx_r      <= shifted_s[0];
                            bit_idx_r <= next_idx_s;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        tx_r      <= 1'b1;
                        bit_idx_r <= {IDX_W{1'b0}};
                        state_r   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_STOP_IDX) begin
                            // Frame complete: done and !busy land together in
                            // the first idle cycle, where a new send is taken.
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            bit_idx_r <= {IDX_W{1'b0}};
                            state_r   <= ST_IDLE;
                        end else begin
                            bit_idx_r <= next_idx_s;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_idx_r <= {IDX_W{1'b0}};
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx   = tx_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Directed plus randomized checks of the UART serializer at
//   CLK_FREQ=1 MHz, BAUD=100 kHz (10 clocks per bit), 8 data bits, 1 stop bit.
//   With UART_PARITY_EN defined the expected frames include the parity bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int C          = 10;
    localparam int DBITS      = 8;
    localparam int SBITS      = 1;
    localparam int PAR_ODD    = 0;
`ifdef UART_PARITY_EN
    localparam int PBITS      = 1;
`else
    localparam int PBITS      = 0;
`endif
    localparam int FRAME      = (1 + DBITS + PBITS + SBITS) * C;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_serializer_if #(.DATA_BITS(DBITS)) bus ();

    uart_tx_serializer #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .DATA_BITS  (DBITS),
        .STOP_BITS  (SBITS),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: line level k cycles after acceptance (k = 1..FRAME).
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        b = (k - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= DBITS) return d[b-1];
`ifdef UART_PARITY_EN
        if (b == DBITS + 1) begin
            int ones;
            ones = 0;
            for (int i = 0; i < DBITS; i++) ones += d[i];
            return (PAR_ODD != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".tx"},   bus.tx,   1'b1);
        chk({tag, ".busy"}, bus.busy, 1'b0);
        chk({tag, ".done"}, bus.done, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk_idle($sformatf("idle%0d", i));
            tick();
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        bus.data_in = d;
        bus.send    = 1'b1;
        tick();
        bus.send    = 1'b0;
    endtask

    // Checks periods 1..last of a frame; ignore_at injects a send while busy.
    task automatic check_cycles(input logic [7:0] d, input int last, input int ignore_at);
        for (int k = 1; k <= last; k++) begin
            chk($sformatf("tx[%0d] d=%02h", k, d), bus.tx, exp_tx(d, k));
            chk($sformatf("busy[%0d]", k), bus.busy, 1'b1);
            chk($sformatf("done[%0d]", k), bus.done, 1'b0);
            bus.send    = (k == ignore_at);
            bus.data_in = (k == ignore_at) ? 8'hFF : 8'($urandom);
            if (k != last) tick();
        end
    endtask

    // Full frame, ending in the done cycle.
    task automatic check_frame(input logic [7:0] d, input int ignore_at);
        check_cycles(d, FRAME, ignore_at);
        bus.send = 1'b0;
        tick();
        chk("done_pulse", bus.done, 1'b1);
        chk("done_busy",  bus.busy, 1'b0);
        chk("done_tx",    bus.tx,   1'b1);
    endtask

    initial begin
        logic [7:0] d;
        rst_n       = 1'b0;
        bus.send    = 1'b1;
        bus.data_in = 8'h5A;

        // Reset held with send asserted: no frame may start.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("rst%0d", i));
        end
        bus.send = 1'b0;
        rst_n    = 1'b1;
        tick();
        idle(3);

        // 8'hA5 frame, then single done pulse.
        start_frame(8'hA5);
        check_frame(8'hA5, 0);
        tick();
        idle(2);

        // Send while busy at cycle 30 ignored; 3C chained in the done cycle.
        start_frame(8'hA5);
        check_frame(8'hA5, 30);
        start_frame(8'h3C);
        check_frame(8'h3C, 0);
        tick();
        idle(2);

        // Reset at cycle 45 aborts the frame without a done pulse.
        d = 8'($urandom);
        start_frame(d);
        check_cycles(d, 45, 0);
        rst_n = 1'b0;
        tick();
        chk_idle("midrst");
        rst_n = 1'b1;
        tick();
        idle(3);

        // Fresh frame after the abort.
        d = 8'($urandom);
        start_frame(d);
        check_frame(d, 0);
        tick();
        idle(1);

        // Randomized frames, random ignored sends, random chaining.
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            start_frame(d);
            check_frame(d, int'($urandom_range(FRAME, 1)));
            if ($urandom_range(1, 0) == 0) begin
                tick();
                idle(int'($urandom_range(3, 1)));
            end
        end
        tick();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_serializer
